// File: rtl/mouse_tracker.sv
// mouse_tracker: assembles 3-byte PS/2 mouse packets into a clamped absolute cursor and button state
module mouse_tracker #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] btn,
    output logic       pkt_valid,
    output logic       sync_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [11:0] XM = 12'(X_MAX);
    localparam logic signed [11:0] YM = 12'(Y_MAX);
    typedef enum logic [1:0] {B0, B1, B2, APPLY} state_t;
    state_t r_state;
    logic [2:0] r_btn;
    logic [1:0] r_sgn;
    logic [1:0] r_ovf;
    logic [7:0] r_xb;
    logic [7:0] r_yb;
    logic [CW-1:0] r_cnt;
    logic r_pend;
    logic w_wait;
    logic w_tmo;
    logic w_hdr_slot;
    logic w_hdr_ok;
    logic w_hdr_bad;
    logic w_apply;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic [9:0] w_cx;
    logic [9:0] w_cy;
    // Decide whether an incoming byte is a header candidate and detect aborts
    always_comb begin
        w_wait     = r_state == B1 || r_state == B2;
        w_tmo      = w_wait && r_cnt == CW'(TIMEOUT);
        w_hdr_slot = !w_wait || w_tmo;
        w_hdr_ok   = rx_valid && !rx_err && w_hdr_slot && rx_data[3];
        w_hdr_bad  = rx_valid && !rx_err && w_hdr_slot && !rx_data[3];
        w_apply    = r_state == APPLY && !rx_err;
    end
    // Signed delta accumulation (PS/2 +y is up, screen +y is down) clamped to the visible area
    always_comb begin
        w_dx = r_ovf[0] ? 12'sd0 : {{4{r_sgn[0]}}, r_xb};
        w_dy = r_ovf[1] ? 12'sd0 : {{4{r_sgn[1]}}, r_yb};
        w_nx = $signed({2'b00, mouse_x}) + w_dx;
        w_ny = $signed({2'b00, mouse_y}) - w_dy;
        w_cx = w_nx < 12'sd0 ? 10'd0 : w_nx > XM ? 10'(X_MAX) : w_nx[9:0];
        w_cy = w_ny < 12'sd0 ? 10'd0 : w_ny > YM ? 10'(Y_MAX) : w_ny[9:0];
    end
    // Packet FSM, inter-byte timeout and registered outputs; a bad header seen during APPLY
    // reports its sync_err one cycle late so it never overlaps pkt_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= B0;
            r_btn     <= '0;
            r_sgn     <= '0;
            r_ovf     <= '0;
            r_xb      <= '0;
            r_yb      <= '0;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            mouse_x   <= 10'(X_INIT);
            mouse_y   <= 10'(Y_INIT);
            btn       <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= w_apply;
            sync_err  <= rx_err || w_tmo || (w_hdr_bad && r_state != APPLY) || r_pend;
            r_pend    <= w_hdr_bad && r_state == APPLY;
            r_cnt     <= (w_wait && !w_tmo && !rx_valid && !rx_err) ? r_cnt + CW'(1) : '0;
            if (w_apply) begin
                mouse_x <= w_cx;
                mouse_y <= w_cy;
                btn     <= r_btn;
            end
            if (rx_err) begin
                r_state <= B0;
            end else if (w_hdr_slot) begin
                r_state <= w_hdr_ok ? B1 : B0;
                if (w_hdr_ok) begin
                    r_btn <= rx_data[2:0];
                    r_sgn <= rx_data[5:4];
                    r_ovf <= rx_data[7:6];
                end
            end else if (rx_valid) begin
                if (r_state == B1) begin
                    r_xb    <= rx_data;
                    r_state <= B2;
                end else begin
                    r_yb    <= rx_data;
                    r_state <= APPLY;
                end
            end
        end
    end
endmodule

// File: tb/tb_mouse_tracker.sv
// tb_mouse_tracker: scoreboard bench with a packet-level reference model of the mouse tracker
module tb_mouse_tracker;
    localparam int T = 40;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_valid = 1'b0;
    logic rx_err = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] btn;
    logic pkt_valid;
    logic sync_err;

    mouse_tracker #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .btn(btn), .pkt_valid(pkt_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_pkt; int x; int y; int b;} ev_t;
    ev_t exp_q[$];
    ev_t got;
    int n_cmp = 0;
    int n_bad = 0;
    int mx = 320;
    int my = 240;
    int mb = 0;
    int nbytes = 0;
    bit pend = 0;
    logic [7:0] pk [3];

    function automatic void push(bit p);
        ev_t e;
        e.is_pkt = p;
        e.x = mx;
        e.y = my;
        e.b = mb;
        exp_q.push_back(e);
    endfunction

    function automatic int clamp(int v, int hi);
        return v < 0 ? 0 : (v > hi ? hi : v);
    endfunction

    function automatic void apply_pkt();
        logic [7:0] h;
        int dx, dy;
        h  = pk[0];
        dx = h[6] ? 0 : int'(pk[1]) - (h[4] ? 256 : 0);
        dy = h[7] ? 0 : int'(pk[2]) - (h[5] ? 256 : 0);
        mx = clamp(mx + dx, 639);
        my = clamp(my - dy, 479);
        mb = int'(h[2:0]);
        push(1);
    endfunction

    task automatic step(bit v, bit e, logic [7:0] d);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_err   = e;
        rx_data  = d;
    endtask

    task automatic item(logic [7:0] b, bit v, bit e, int g);
        bit dropped;
        dropped = 0;
        if (pend) begin
            pend = 0;
            if (g == 0 && e) begin
                push(0);
                dropped = 1;
            end else begin
                apply_pkt();
            end
        end
        if (!dropped) begin
            if (nbytes > 0 && g >= T) begin
                push(0);
                nbytes = 0;
            end
            if (e) begin
                push(0);
                nbytes = 0;
            end else if (v) begin
                if (nbytes == 0) begin
                    if (b[3]) begin
                        pk[0]  = b;
                        nbytes = 1;
                    end else begin
                        push(0);
                    end
                end else begin
                    pk[nbytes] = b;
                    nbytes++;
                    if (nbytes == 3) begin
                        nbytes = 0;
                        pend   = 1;
                    end
                end
            end
        end
        repeat (g) step(0, 0, 8'h00);
        step(v, e, b);
    endtask

    task automatic pkt3(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        item(a, 1, 0, 0);
        item(b, 1, 0, 0);
        item(c, 1, 0, 0);
    endtask

    task automatic flush();
        if (pend) begin
            pend = 0;
            apply_pkt();
        end else if (nbytes > 0) begin
            push(0);
            nbytes = 0;
        end
        repeat (T + 10) step(0, 0, 8'h00);
    endtask

    task automatic chk(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00);
        reset = 1'b0;
        mx = 320;
        my = 240;
        mb = 0;
        nbytes = 0;
        pend = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (pkt_valid || sync_err) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_pulse: pkt_valid=%0b sync_err=%0b with nothing expected", pkt_valid, sync_err);
                    end else begin
                        got = exp_q.pop_front();
                        if (pkt_valid && sync_err) begin
                            n_bad++;
                            $display("FAIL pulse_overlap: pkt_valid=1 sync_err=1, required exactly one");
                        end else if (pkt_valid != got.is_pkt) begin
                            n_bad++;
                            $display("FAIL pulse_kind: got pkt_valid=%0b sync_err=%0b, required pkt_valid=%0b", pkt_valid, sync_err, got.is_pkt);
                        end else if (pkt_valid && (int'(mouse_x) != got.x || int'(mouse_y) != got.y || int'(btn) != got.b)) begin
                            n_bad++;
                            $display("FAIL packet_result: got x=%0d y=%0d btn=%0d, required x=%0d y=%0d btn=%0d", mouse_x, mouse_y, btn, got.x, got.y, got.b);
                        end
                    end
                end
            end
        join_none

        do_reset();
        repeat (100) step(0, 0, 8'h00);
        chk("reset_x", int'(mouse_x), 320);
        chk("reset_y", int'(mouse_y), 240);
        chk("reset_btn", int'(btn), 0);

        pkt3(8'h09, 8'h0A, 8'h05);
        flush();
        chk("basic_x", int'(mouse_x), 330);
        chk("basic_y", int'(mouse_y), 235);
        chk("basic_btn", int'(btn), 1);

        do_reset();
        pkt3(8'h18, 8'h01, 8'h00);
        flush();
        chk("neg_dx_x", int'(mouse_x), 65);
        pkt3(8'h18, 8'h01, 8'h00);
        flush();
        chk("clamp_x0", int'(mouse_x), 0);
        for (int i = 0; i < 3; i++) begin
            pkt3(8'h28, 8'h00, 8'h01);
            flush();
            chk("clamp_ymax", int'(mouse_y), 479);
        end

        pkt3(8'h4E, 8'h7F, 8'h10);
        flush();
        chk("ovf_x", int'(mouse_x), 0);
        chk("ovf_y", int'(mouse_y), 463);
        chk("ovf_btn", int'(btn), 6);

        item(8'h05, 1, 0, 0);
        pkt3(8'h08, 8'h01, 8'h01);
        flush();
        chk("resync_x", int'(mouse_x), 1);
        chk("resync_y", int'(mouse_y), 462);

        item(8'h08, 1, 0, 0);
        item(8'h01, 1, 0, 0);
        flush();
        chk("timeout_x", int'(mouse_x), 1);
        chk("timeout_y", int'(mouse_y), 462);

        item(8'h08, 1, 0, 0);
        item(8'h01, 1, 1, 0);
        pkt3(8'h08, 8'h01, 8'h01);
        flush();
        chk("err_drop_x", int'(mouse_x), 2);
        chk("err_drop_y", int'(mouse_y), 461);

        pkt3(8'h08, 8'h02, 8'h02);
        item(8'h00, 0, 1, 0);
        flush();
        chk("apply_err_x", int'(mouse_x), 2);
        chk("apply_err_y", int'(mouse_y), 461);

        pkt3(8'h08, 8'h02, 8'h02);
        item(8'h00, 1, 0, 0);
        flush();
        chk("apply_badbyte_x", int'(mouse_x), 4);
        chk("apply_badbyte_y", int'(mouse_y), 459);

        for (int i = 0; i < 300; i++) begin
            int r;
            int g;
            logic [7:0] b;
            bit e;
            bit v;
            r = int'($urandom_range(0, 99));
            g = ($urandom_range(0, 15) == 0) ? T + 5 + int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
            b = 8'($urandom);
            e = r < 8;
            v = !e || ($urandom_range(0, 1) == 1);
            if (!e && (nbytes == 0 || pend || g >= T) && r < 80) b[3] = 1'b1;
            if ((e || (!b[3] && (nbytes == 0 || pend || g >= T))) && g < 2) g = 2;
            item(b, v, e, g);
        end
        flush();
        chk("queue_drained", exp_q.size(), 0);
        chk("final_x", int'(mouse_x), mx);
        chk("final_y", int'(mouse_y), my);
        chk("final_btn", int'(btn), mb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
